alu_seq_unit: RTL and testbench

//  Multi-cycle ALU for the DAPA2014 datapath; sits directly upstream of the status register.

---
 rtl/alu_seq_unit.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//
// Multi-cycle ALU for the DAPA2014 datapath, feeding the status register.
// Produces a registered result plus flags {v,n,z,c} and pulses ws so the
// status register latches the flags. Logic and add/sub ops complete in one
// cycle. Shifts iterate one bit per cycle. The optional shift-add multiply
// iterates one multiplier bit per cycle.
//
// Build option:
//   ALU_SEQ_MUL_EN  when defined, op 4'b1000 is an unsigned multiply (low
//                   WIDTH bits of a*b). When undefined, op 4'b1000 is an
//                   illegal op and no multiplier logic exists.
//
// Ports:
//   clk     in   1      clock, rising edge
//   reset   in   1      synchronous, active-high; aborts any op in flight
//   start   in   1      request, sampled only while idle
//   op      in   4      operation code, latched with start
//   a       in   WIDTH  operand A, latched with start
//   b       in   WIDTH  operand B; shift amount is b[SAW-1:0]
//   result  out  WIDTH  registered result, holds until the next done
//   v,n,z,c out  1      registered flags, valid while ws=1, hold afterwards
//   ws      out  1      one-cycle flag write strobe (legal ops only)
//   busy    out  1      high from the cycle after accept through the done cycle
//   done    out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH = 8,
    parameter int SAW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             v,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             ws,
    output logic             busy,
    output logic             done
);

    // Counter holds up to WIDTH (multiply iterations), so one extra bit.
    localparam int CW = SAW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Two's-complement overflow: operands of equal sign whose sum flips sign.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Subtraction overflows when operand signs differ and the result takes
    // the sign of the subtrahend.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Control state
    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ws_q, ws_d;

    // Architectural outputs
    logic [WIDTH-1:0] result_q, result_d;
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;

    // Iteration datapath (not reset; only meaningful while in EXEC)
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_nx;
`endif

    // Completion request gathered from every op path, applied once at the end.
    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_v;
    logic             ill;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ws_d     = 1'b0;
        result_d = result_q;
        v_d      = v_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        fin      = 1'b0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;
        ill      = 1'b0;
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
`ifdef ALU_SEQ_MUL_EN
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_nx  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    op_d   = op;
                    case (op)
                        OP_ADD: begin
                            fin     = 1'b1;
                            fin_res = sum[WIDTH-1:0];
                            fin_c   = sum[WIDTH];
                            fin_v   = add_ovf(a, b, sum[WIDTH-1:0]);
                        end
                        OP_SUB: begin
                            // Top bit of the extended difference is the borrow.
                            fin     = 1'b1;
                            fin_res = diff[WIDTH-1:0];
                            fin_c   = diff[WIDTH];
                            fin_v   = sub_ovf(a, b, diff[WIDTH-1:0]);
                        end
                        OP_AND: begin
                            fin     = 1'b1;
                            fin_res = a & b;
                        end
                        OP_OR: begin
                            fin     = 1'b1;
                            fin_res = a | b;
                        end
                        OP_XOR: begin
                            fin     = 1'b1;
                            fin_res = a ^ b;
                        end
                        OP_NOT: begin
                            fin     = 1'b1;
                            fin_res = ~a;
                        end
                        OP_SHL, OP_SHR: begin
                            // Zero-amount shifts skip EXEC entirely.
                            if (b[SAW-1:0] == '0) begin
                                fin     = 1'b1;
                                fin_res = a;
                            end else begin
                                state_d = S_EXEC;
                                cnt_d   = {1'b0, b[SAW-1:0]};
                                sh_d    = a;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            state_d  = S_EXEC;
                            cnt_d    = CW'(WIDTH);
                            prod_d   = '0;
                            mcand_d  = {{WIDTH{1'b0}}, a};
                            mplier_d = b;
                        end
`endif
                        default: ill = 1'b1;
                    endcase
                end
            end

            S_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                case (op_q)
                    OP_SHL: begin
                        sh_d = {sh_q[WIDTH-2:0], 1'b0};
                        if (cnt_q == CW'(1)) begin
                            fin     = 1'b1;
                            fin_res = sh_d;
                            fin_c   = sh_q[WIDTH-1];
                        end
                    end
                    OP_SHR: begin
                        sh_d = {1'b0, sh_q[WIDTH-1:1]};
                        if (cnt_q == CW'(1)) begin
                            fin     = 1'b1;
                            fin_res = sh_d;
                            fin_c   = sh_q[0];
                        end
                    end
`ifdef ALU_SEQ_MUL_EN
                    OP_MUL: begin
                        prod_d   = prod_nx;
                        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                        if (cnt_q == CW'(1)) begin
                            fin     = 1'b1;
                            fin_res = prod_nx[WIDTH-1:0];
                            fin_c   = |prod_nx[2*WIDTH-1:WIDTH];
                            fin_v   = |prod_nx[2*WIDTH-1:WIDTH];
                        end
                    end
`endif
                    default: begin
                        // Unreachable: only iterative ops enter EXEC.
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end

            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (fin) begin
            state_d  = S_FIN;
            result_d = fin_res;
            v_d      = fin_v;
            c_d      = fin_c;
            n_d      = fin_res[WIDTH-1];
            z_d      = (fin_res == '0);
            ws_d     = 1'b1;
            done_d   = 1'b1;
        end

        // Illegal op: completes without a flag write, flags keep their value.
        if (ill) begin
            state_d  = S_FIN;
            result_d = '0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        cnt_q <= cnt_d;
        sh_q  <= sh_d;
`ifdef ALU_SEQ_MUL_EN
        prod_q   <= prod_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
`endif
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ws_q     <= 1'b0;
            result_q <= '0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ws_q     <= ws_d;
            result_q <= result_d;
            v_q      <= v_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
        end
    end

    assign result = result_q;
    assign v      = v_q;
    assign n      = n_q;
    assign z      = z_q;
    assign c      = c_q;
    assign ws     = ws_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_unit
//
// Self-checking bench for alu_seq_unit (WIDTH=8): a directed vector table, a
// few multi-cycle corner sequences, then random ops against a plain-arithmetic
// reference model. Honours ALU_SEQ_MUL_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       v, n, z, c;
    logic       ws, busy, done;

    int errs   = 0;
    int checks = 0;

    // Model copy of the status flags (held across illegal ops).
    logic mv = 1'b0, mn = 1'b0, mz = 1'b0, mc = 1'b0;

    alu_seq_unit #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .v      (v),
        .n      (n),
        .z      (z),
        .c      (c),
        .ws     (ws),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      nm;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       v, n, z, c;
        logic       ws;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model from the op definitions using integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] r, output logic fv, output logic fn,
                         output logic fz, output logic fc, output logic fws,
                         output int lat);
        int ux, uy, sx, sy, s, t, amt;
        bit legal;
        ux = x; uy = y;
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        amt = uy % 8;
        legal = 1'b1;
        fv = 1'b0; fc = 1'b0; lat = 1; r = 8'h00; t = 0;
        case (o)
            4'h0: begin t = ux + uy; r = t[7:0]; fc = (t > 255);
                        s = sx + sy; fv = (s > 127) || (s < -128); end
            4'h1: begin t = ux - uy; r = t[7:0]; fc = (ux < uy);
                        s = sx - sy; fv = (s > 127) || (s < -128); end
            4'h2: begin t = ux & uy; r = t[7:0]; end
            4'h3: begin t = ux | uy; r = t[7:0]; end
            4'h4: begin t = ux ^ uy; r = t[7:0]; end
            4'h5: begin t = 255 - ux; r = t[7:0]; end
            4'h6: begin t = (ux << amt) % 256; r = t[7:0];
                        fc = (amt > 0) ? (((ux >> (8 - amt)) & 1) == 1) : 1'b0;
                        lat = 1 + amt; end
            4'h7: begin t = ux >> amt; r = t[7:0];
                        fc = (amt > 0) ? (((ux >> (amt - 1)) & 1) == 1) : 1'b0;
                        lat = 1 + amt; end
`ifdef ALU_SEQ_MUL_EN
            4'h8: begin t = ux * uy; r = t[7:0];
                        fc = (t / 256) != 0; fv = fc; lat = 9; end
`endif
            default: legal = 1'b0;
        endcase
        if (legal) begin
            fn = r[7]; fz = (r == 8'h00); fws = 1'b1;
        end else begin
            r = 8'h00; fv = mv; fn = mn; fz = mz; fc = mc; fws = 1'b0; lat = 1;
        end
    endtask

    // Issue one op from idle and check its completion against expectations.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [7:0] ia,
                          input logic [7:0] ib, input logic [7:0] er, input logic ev,
                          input logic en, input logic ez, input logic ec,
                          input logic ews, input int elat);
        int lat, bad;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        @(negedge clk);
        // Scramble inputs so only latched operands can produce the answer.
        start = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1; bad = 0;
        while (!done && lat < 40) begin
            if (!busy || ws) bad++;
            @(negedge clk);
            lat++;
        end
        seen = done;
        chk({nm, " done_seen"}, int'(seen), 1);
        chk({nm, " latency"}, lat, elat);
        chk({nm, " busy_at_done"}, int'(busy), 1);
        chk({nm, " ws"}, int'(ws), int'(ews));
        chk({nm, " result"}, int'(result), int'(er));
        chk({nm, " flags_vnzc"}, int'({v, n, z, c}), int'({ev, en, ez, ec}));
        chk({nm, " busy_gap_or_early_ws"}, bad, 0);
        @(negedge clk);
        chk({nm, " after_done_ws_busy"}, int'({done, ws, busy}), 0);
        if (ews) begin
            mv = ev; mn = en; mz = ez; mc = ec;
        end
    endtask

    vec_t vecs[13];

    initial begin
        logic [7:0] er;
        logic ev, en, ez, ec, ews;
        int elat, dcount, first;
        logic [7:0] cap;
        logic [3:0] ro;

        reset = 1'b1; start = 1'b1; op = 4'h0; a = 8'h12; b = 8'h34;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({result, v, n, z, c, ws, busy, done}), 0);
        start = 1'b0;
        reset = 1'b0;
        mv = 0; mn = 0; mz = 0; mc = 0;

        //          name        op     a      b      r      v  n  z  c  ws lat
        vecs[0]  = '{"add_ovf",  4'h0, 8'h7F, 8'h01, 8'h80, 1, 1, 0, 0, 1, 1};
        vecs[1]  = '{"sub_zero", 4'h1, 8'h05, 8'h05, 8'h00, 0, 0, 1, 0, 1, 1};
        vecs[2]  = '{"sub_brw",  4'h1, 8'h03, 8'h04, 8'hFF, 0, 1, 0, 1, 1, 1};
        vecs[3]  = '{"shl3",     4'h6, 8'h81, 8'h03, 8'h08, 0, 0, 0, 0, 1, 4};
        vecs[4]  = '{"shl1",     4'h6, 8'h81, 8'h01, 8'h02, 0, 0, 0, 1, 1, 2};
        vecs[5]  = '{"and",      4'h2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1, 1};
        vecs[6]  = '{"or",       4'h3, 8'h0F, 8'hF0, 8'hFF, 0, 1, 0, 0, 1, 1};
        vecs[7]  = '{"xor_zero", 4'h4, 8'hAA, 8'hAA, 8'h00, 0, 0, 1, 0, 1, 1};
        vecs[8]  = '{"not",      4'h5, 8'h55, 8'h00, 8'hAA, 0, 1, 0, 0, 1, 1};
        vecs[9]  = '{"shr_amt0", 4'h7, 8'h81, 8'h08, 8'h81, 0, 1, 0, 0, 1, 1};
        vecs[10] = '{"add_carry",4'h0, 8'hFF, 8'h01, 8'h00, 0, 0, 1, 1, 1, 1};
        vecs[11] = '{"sub_ovf",  4'h1, 8'h80, 8'h01, 8'h7F, 1, 0, 0, 0, 1, 1};
        vecs[12] = '{"illegal",  4'hF, 8'h12, 8'h34, 8'h00, 1, 0, 0, 0, 0, 1};

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
                   vecs[i].v, vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].ws, vecs[i].lat);
        end

`ifdef ALU_SEQ_MUL_EN
        run_op("mul_10x10", 4'h8, 8'h10, 8'h10, 8'h00, 1, 0, 1, 1, 1, 9);
        run_op("mul_0d_0b", 4'h8, 8'h0D, 8'h0B, 8'h8F, 0, 1, 0, 0, 1, 9);
`else
        run_op("mul_disabled", 4'h8, 8'h10, 8'h10, 8'h00, mv, mn, mz, mc, 0, 1);
`endif

        // start pulsed while an SHR of 5 is in flight must be ignored.
        @(negedge clk);
        start = 1'b1; op = 4'h7; a = 8'hA5; b = 8'h05;
        @(negedge clk);
        start = 1'b0;
        dcount = 0; first = 0; cap = 8'h00;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin start = 1'b1; op = 4'h0; a = 8'h01; b = 8'h01; end
            if (i == 3) start = 1'b0;
            if (done) begin
                dcount++;
                if (first == 0) begin first = i; cap = result; end
            end
            @(negedge clk);
        end
        chk("busy_start_done_count", dcount, 1);
        chk("busy_start_latency", first, 6);
        chk("busy_start_result", int'(cap), 8'h05);
        chk("busy_start_flags", int'({v, n, z, c}), 0);
        mv = 0; mn = 0; mz = 0; mc = 0;

        // start held through the FIN cycle must not start a second op.
        @(negedge clk);
        start = 1'b1; op = 4'h0; a = 8'h01; b = 8'h02;
        @(negedge clk);
        chk("fin_start_first_done", int'(done), 1);
        @(negedge clk);
        start = 1'b0;
        chk("fin_start_no_done_c2", int'(done), 0);
        @(negedge clk);
        chk("fin_start_no_done_c3", int'(done), 0);
        chk("fin_start_result", int'(result), 8'h03);

        // Reset in the middle of a long shift.
        @(negedge clk);
        start = 1'b1; op = 4'h6; a = 8'h81; b = 8'h07;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midop_reset_outputs", int'({result, v, n, z, c, ws, busy, done}), 0);
        reset = 1'b0;
        mv = 0; mn = 0; mz = 0; mc = 0;
        repeat (9) @(negedge clk);
        chk("midop_reset_no_late_done", int'(done), 0);
        run_op("add_after_reset", 4'h0, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 1, 1);

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            if ($urandom_range(0, 7) == 0) ro = 4'($urandom_range(9, 15));
            else ro = 4'($urandom_range(0, 8));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rb = 8'h00;
            model(ro, ra, rb, er, ev, en, ez, ec, ews, elat);
            run_op($sformatf("rand%0d_op%0h", i, ro), ro, ra, rb, er, ev, en, ez, ec, ews, elat);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
